// File: rtl/floo_pkg.sv
// Shared chimney types and defaults for the burst reorder buffer.
package floo_pkg;

   localparam int unsigned RobSizeDflt   = 64;
   localparam int unsigned MaxBeatsDflt  = 4;
   localparam int unsigned RobDataDflt   = 64;
   localparam int unsigned RobIdxDflt    = $clog2(RobSizeDflt);

   typedef logic [RobIdxDflt-1:0] rob_idx_t;

   typedef struct packed {
      logic [RobDataDflt-1:0] data;
      logic                   last;
   } rob_beat_t;

   function automatic bit is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/floo_rob_slot_mem.sv
// Slot storage for the burst ROB: payload/last flops plus per-slot alloc and valid bits.
module floo_rob_slot_mem
   import floo_pkg::*;
#(
   parameter int unsigned RobSize     = RobSizeDflt,
   parameter int unsigned DataWidth   = RobDataDflt,
   parameter int unsigned RobIdxWidth = $clog2(RobSize),
   parameter int unsigned LenWidth    = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   alloc_en_i,
   input  logic [RobIdxWidth-1:0] alloc_base_i,
   input  logic [LenWidth-1:0]    alloc_len_i,
   input  logic                   wr_en_i,
   input  logic [RobIdxWidth-1:0] wr_idx_i,
   input  logic [DataWidth-1:0]   wr_data_i,
   input  logic                   rel_en_i,
   input  logic [RobIdxWidth-1:0] rd_idx_i,
   output logic                   wr_ok_o,
   output logic                   rd_valid_o,
   output logic [DataWidth-1:0]   rd_data_o,
   output logic                   rd_last_o
);

   typedef struct packed {
      logic [DataWidth-1:0] data;
      logic                 last;
   } slot_t;

   slot_t              slots_q [RobSize];
   logic [RobSize-1:0] alloc_q, valid_q;
   logic [RobSize-1:0] alloc_mask, last_mask;
   logic               wr_fire;

   // Distance from the burst base modulo RobSize lets a burst straddle the index wrap.
   for (genvar i = 0; i < RobSize; i++) begin : g_mask
      logic [RobIdxWidth-1:0] offset;
      assign offset        = RobIdxWidth'(i) - alloc_base_i;
      assign alloc_mask[i] = alloc_en_i && (offset <= RobIdxWidth'(alloc_len_i));
      assign last_mask[i]  = alloc_en_i && (offset == RobIdxWidth'(alloc_len_i));
   end

   assign wr_ok_o = alloc_q[wr_idx_i] && !valid_q[wr_idx_i];
   assign wr_fire = wr_en_i && wr_ok_o;

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values;
   // the later bit-level clear for the released head wins over the vector update.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         alloc_q <= '0;
         valid_q <= '0;
      end else begin
         alloc_q <= alloc_q | alloc_mask;
         if (wr_fire) valid_q[wr_idx_i] <= 1'b1;
         if (rel_en_i) begin
            alloc_q[rd_idx_i] <= 1'b0;
            valid_q[rd_idx_i] <= 1'b0;
         end
      end
   end

   // NOTE: payload flops have no reset; the alloc/valid bits gate every read of them.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < RobSize; i++) begin
         if (alloc_mask[i]) slots_q[i].last <= last_mask[i];
      end
      if (wr_fire) slots_q[wr_idx_i].data <= wr_data_i;
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_data_o  = slots_q[rd_idx_i].data;
   assign rd_last_o  = slots_q[rd_idx_i].last;

endmodule

// File: rtl/floo_burst_rob.sv
// In-order release buffer for burst responses: reserves slot runs, accepts tagged beats, drains in order.
module floo_burst_rob
   import floo_pkg::*;
#(
   parameter int unsigned RobSize     = RobSizeDflt,
   parameter int unsigned DataWidth   = RobDataDflt,
   parameter int unsigned MaxBeats    = MaxBeatsDflt,
   parameter int unsigned RobIdxWidth = $clog2(RobSize),
   parameter int unsigned LenWidth    = (MaxBeats > 1) ? $clog2(MaxBeats) : 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   alloc_valid_i,
   input  logic [LenWidth-1:0]    alloc_len_i,
   output logic                   alloc_ready_o,
   output logic [RobIdxWidth-1:0] alloc_idx_o,
   input  logic                   rsp_valid_i,
   output logic                   rsp_ready_o,
   input  logic [RobIdxWidth-1:0] rsp_idx_i,
   input  logic [DataWidth-1:0]   rsp_data_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [DataWidth-1:0]   out_data_o,
   output logic                   out_last_o,
   output logic [RobIdxWidth:0]   num_free_o,
   output logic                   err_o
);

   localparam int unsigned PtrWidth = RobIdxWidth + 1;
   typedef logic [PtrWidth-1:0] ptr_t;

   ptr_t head_q, tail_q;
   ptr_t alloc_need;
   logic alloc_fire, rel_fire, wr_ok, err_q;

   // The extra wrap bit distinguishes full from empty when the indices match.
   assign num_free_o    = PtrWidth'(RobSize) - (tail_q - head_q);
   assign alloc_need    = PtrWidth'(alloc_len_i) + PtrWidth'(1);
   assign alloc_ready_o = (num_free_o >= alloc_need);
   assign alloc_idx_o   = tail_q[RobIdxWidth-1:0];
   assign alloc_fire    = alloc_valid_i && alloc_ready_o;
   assign rsp_ready_o   = 1'b1;
   assign rel_fire      = out_valid_o && out_ready_i;
   assign err_o         = err_q;

   floo_rob_slot_mem #(
      .RobSize     (RobSize),
      .DataWidth   (DataWidth),
      .RobIdxWidth (RobIdxWidth),
      .LenWidth    (LenWidth)
   ) i_slot_mem (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .alloc_en_i   (alloc_fire),
      .alloc_base_i (tail_q[RobIdxWidth-1:0]),
      .alloc_len_i  (alloc_len_i),
      .wr_en_i      (rsp_valid_i),
      .wr_idx_i     (rsp_idx_i),
      .wr_data_i    (rsp_data_i),
      .rel_en_i     (rel_fire),
      .rd_idx_i     (head_q[RobIdxWidth-1:0]),
      .wr_ok_o      (wr_ok),
      .rd_valid_o   (out_valid_o),
      .rd_data_o    (out_data_o),
      .rd_last_o    (out_last_o)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head_q <= '0;
         tail_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (alloc_fire) tail_q <= tail_q + alloc_need;
         if (rel_fire)   head_q <= head_q + PtrWidth'(1);
         if (rsp_valid_i && !wr_ok) err_q <= 1'b1;
      end
   end

   param_ok: assert property (@(posedge clk_i)
      is_pow2(RobSize) && (RobSize >= 4) && (RobSize >= MaxBeats));

   out_hold: assert property (@(posedge clk_i) disable iff (rst_i)
      (out_valid_o && !out_ready_i) |=> (out_valid_o && $stable(out_data_o)));

endmodule

// File: tb/tb_floo_burst_rob.sv
// Self-checking bench for floo_burst_rob: vector table, directed corner cases, randomized model run.
module tb_floo_burst_rob;

   localparam int RobSize   = 8;
   localparam int DataWidth = 16;
   localparam int MaxBeats  = 4;
   localparam int IdxW      = 3;
   localparam int LenW      = 2;

   logic                 clk_i = 1'b0;
   logic                 rst_i = 1'b1;
   logic                 alloc_valid_i = 1'b0;
   logic [LenW-1:0]      alloc_len_i = '0;
   logic                 alloc_ready_o;
   logic [IdxW-1:0]      alloc_idx_o;
   logic                 rsp_valid_i = 1'b0;
   logic                 rsp_ready_o;
   logic [IdxW-1:0]      rsp_idx_i = '0;
   logic [DataWidth-1:0] rsp_data_i = '0;
   logic                 out_valid_o;
   logic                 out_ready_i = 1'b0;
   logic [DataWidth-1:0] out_data_o;
   logic                 out_last_o;
   logic [IdxW:0]        num_free_o;
   logic                 err_o;

   floo_burst_rob #(
      .RobSize   (RobSize),
      .DataWidth (DataWidth),
      .MaxBeats  (MaxBeats)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .alloc_valid_i (alloc_valid_i),
      .alloc_len_i   (alloc_len_i),
      .alloc_ready_o (alloc_ready_o),
      .alloc_idx_o   (alloc_idx_o),
      .rsp_valid_i   (rsp_valid_i),
      .rsp_ready_o   (rsp_ready_o),
      .rsp_idx_i     (rsp_idx_i),
      .rsp_data_i    (rsp_data_i),
      .out_valid_o   (out_valid_o),
      .out_ready_i   (out_ready_i),
      .out_data_o    (out_data_o),
      .out_last_o    (out_last_o),
      .num_free_o    (num_free_o),
      .err_o         (err_o)
   );

   always #5 clk_i = ~clk_i;

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      else pass_cnt++;
   endtask

   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic idle();
      alloc_valid_i = 1'b0;
      alloc_len_i   = '0;
      rsp_valid_i   = 1'b0;
      out_ready_i   = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic alloc(input int len);
      alloc_valid_i = 1'b1;
      alloc_len_i   = LenW'(len);
      tick();
      alloc_valid_i = 1'b0;
      alloc_len_i   = '0;
   endtask

   task automatic write(input int idx, input int data);
      rsp_valid_i = 1'b1;
      rsp_idx_i   = IdxW'(idx);
      rsp_data_i  = DataWidth'(data);
      tick();
      rsp_valid_i = 1'b0;
   endtask

   typedef struct {
      int av, alen, rv, ridx, ordy;
      int eov, edata, elast, enf, eard, eaidx;
   } vec_t;

   vec_t vecs[12];

   // Behavioural reference: slot table indexed by position, plus occupancy count.
   int m_head, m_used, m_err;
   bit m_alloc[RobSize];
   bit m_valid[RobSize];
   bit m_last[RobSize];
   int m_data[RobSize];

   initial begin
      // Alloc len3 @0, len0 @4, write 4,2,0,3,1; drain 0..4.
      vecs[0]  = '{1, 3, 0, 0, 0,  0, 0,       0, 8, 1, 0};
      vecs[1]  = '{1, 0, 0, 0, 0,  0, 0,       0, 4, 1, 4};
      vecs[2]  = '{0, 0, 1, 4, 0,  0, 0,       0, 3, 1, 5};
      vecs[3]  = '{0, 0, 1, 2, 0,  0, 0,       0, 3, 1, 5};
      vecs[4]  = '{0, 0, 1, 0, 0,  0, 0,       0, 3, 1, 5};
      vecs[5]  = '{0, 0, 1, 3, 1,  1, 'hA000,  0, 3, 1, 5};
      vecs[6]  = '{0, 0, 1, 1, 1,  0, 0,       0, 4, 1, 5};
      vecs[7]  = '{0, 0, 0, 0, 1,  1, 'hA001,  0, 4, 1, 5};
      vecs[8]  = '{0, 0, 0, 0, 1,  1, 'hA002,  0, 5, 1, 5};
      vecs[9]  = '{0, 0, 0, 0, 1,  1, 'hA003,  1, 6, 1, 5};
      vecs[10] = '{0, 0, 0, 0, 1,  1, 'hA004,  1, 7, 1, 5};
      vecs[11] = '{0, 0, 0, 0, 0,  0, 0,       0, 8, 1, 5};

      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid_o), 0);
      check("rst_num_free", 32'(num_free_o), RobSize);
      check("rst_err", 32'(err_o), 0);
      check("rst_alloc_ready", 32'(alloc_ready_o), 1);
      check("rst_rsp_ready", 32'(rsp_ready_o), 1);
      check("rst_alloc_idx", 32'(alloc_idx_o), 0);

      // ---- vector table ----
      for (int i = 0; i < 12; i++) begin
         alloc_valid_i = 1'(vecs[i].av);
         alloc_len_i   = LenW'(vecs[i].alen);
         rsp_valid_i   = 1'(vecs[i].rv);
         rsp_idx_i     = IdxW'(vecs[i].ridx);
         rsp_data_i    = DataWidth'('hA000 + vecs[i].ridx);
         out_ready_i   = 1'(vecs[i].ordy);
         #1;
         check($sformatf("vec%0d_out_valid", i), 32'(out_valid_o), vecs[i].eov);
         check($sformatf("vec%0d_num_free", i), 32'(num_free_o), vecs[i].enf);
         check($sformatf("vec%0d_alloc_ready", i), 32'(alloc_ready_o), vecs[i].eard);
         check($sformatf("vec%0d_alloc_idx", i), 32'(alloc_idx_o), vecs[i].eaidx);
         if (vecs[i].eov != 0) begin
            check($sformatf("vec%0d_out_data", i), 32'(out_data_o), vecs[i].edata);
            check($sformatf("vec%0d_out_last", i), 32'(out_last_o), vecs[i].elast);
         end
         tick();
      end
      idle();
      #1;
      check("vec_err", 32'(err_o), 0);

      // ---- fill ----
      do_reset();
      alloc(3);
      alloc(3);
      #1;
      check("fill_num_free", 32'(num_free_o), 0);
      check("fill_alloc_ready", 32'(alloc_ready_o), 0);
      write(0, 'h1111);
      out_ready_i = 1'b1;
      #1;
      check("fill_head_valid", 32'(out_valid_o), 1);
      tick();
      out_ready_i   = 1'b0;
      alloc_valid_i = 1'b1;
      alloc_len_i   = 2'd1;
      #1;
      check("fill_free_one", 32'(num_free_o), 1);
      check("fill_len1_refused", 32'(alloc_ready_o), 0);
      tick();
      #1;
      check("fill_len1_no_alloc", 32'(num_free_o), 1);
      alloc_len_i = 2'd0;
      #1;
      check("fill_len0_ok", 32'(alloc_ready_o), 1);
      alloc_valid_i = 1'b0;

      // ---- wrap ----
      do_reset();
      alloc(3);
      alloc(1);
      for (int s = 0; s < 6; s++) write(s, s);
      out_ready_i = 1'b1;
      repeat (6) tick();
      out_ready_i   = 1'b0;
      alloc_valid_i = 1'b1;
      alloc_len_i   = 2'd3;
      #1;
      check("wrap_empty_valid", 32'(out_valid_o), 0);
      check("wrap_empty_free", 32'(num_free_o), RobSize);
      check("wrap_alloc_idx", 32'(alloc_idx_o), 6);
      tick();
      alloc_valid_i = 1'b0;
      #1;
      check("wrap_free_after", 32'(num_free_o), 4);
      write(1, 'hB001);
      write(0, 'hB000);
      write(7, 'hB007);
      write(6, 'hB006);
      #1;
      check("wrap_no_err", 32'(err_o), 0);
      out_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         int s;
         s = (6 + k) % RobSize;
         #1;
         check($sformatf("wrap_valid%0d", k), 32'(out_valid_o), 1);
         check($sformatf("wrap_data%0d", k), 32'(out_data_o), 'hB000 + s);
         check($sformatf("wrap_last%0d", k), 32'(out_last_o), (k == 3) ? 1 : 0);
         tick();
      end
      out_ready_i = 1'b0;
      #1;
      check("wrap_drained", 32'(out_valid_o), 0);

      // ---- errors (head = tail = 2 here) ----
      alloc(0);
      write(2, 'hC002);
      rsp_valid_i = 1'b1;
      rsp_idx_i   = 3'd5;
      rsp_data_i  = 16'hEEEE;
      #1;
      check("err_before_edge", 32'(err_o), 0);
      tick();
      rsp_valid_i = 1'b0;
      #1;
      check("err_set", 32'(err_o), 1);
      check("err_out_valid", 32'(out_valid_o), 1);
      check("err_out_data", 32'(out_data_o), 'hC002);
      write(2, 'hDEAD);
      #1;
      check("err_dup_keeps_data", 32'(out_data_o), 'hC002);
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      #1;
      check("err_drained", 32'(out_valid_o), 0);
      check("err_sticky", 32'(err_o), 1);

      // ---- back-pressure ----
      do_reset();
      alloc(3);
      for (int s = 0; s < 4; s++) write(s, 'hD000 + s);
      for (int c = 0; c < 10; c++) begin
         #1;
         check($sformatf("bp_hold_valid%0d", c), 32'(out_valid_o), 1);
         check($sformatf("bp_hold_data%0d", c), 32'(out_data_o), 'hD000);
         tick();
      end
      out_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("bp_rel_valid%0d", k), 32'(out_valid_o), 1);
         check($sformatf("bp_rel_data%0d", k), 32'(out_data_o), 'hD000 + k);
         tick();
      end
      out_ready_i = 1'b0;
      #1;
      check("bp_empty", 32'(out_valid_o), 0);

      // ---- reset mid-burst ----
      do_reset();
      alloc(3);
      for (int s = 0; s < 3; s++) write(s, 'hF000 + s);
      write(6, 'h0666);
      #1;
      check("mid_pre_valid", 32'(out_valid_o), 1);
      check("mid_pre_err", 32'(err_o), 1);
      #1;
      rst_i = 1'b1;
      #1;
      check("mid_rst_valid", 32'(out_valid_o), 0);
      check("mid_rst_free", 32'(num_free_o), RobSize);
      check("mid_rst_err", 32'(err_o), 0);
      @(negedge clk_i);
      rst_i = 1'b0;

      // ---- randomized run against the reference model ----
      do_reset();
      m_head = 0;
      m_used = 0;
      m_err  = 0;
      for (int s = 0; s < RobSize; s++) begin
         m_alloc[s] = 0;
         m_valid[s] = 0;
         m_last[s]  = 0;
         m_data[s]  = 0;
      end
      for (int cyc = 0; cyc < 1500; cyc++) begin
         int pend[$];
         int e_nf, e_tail, len, idx, data;
         bit av, rv, ordy, e_ov, e_ard, wr_ok;
         for (int s = 0; s < RobSize; s++)
            if (m_alloc[s] && !m_valid[s]) pend.push_back(s);
         av   = ($urandom_range(0, 2) == 0);
         len  = int'($urandom_range(0, MaxBeats - 1));
         ordy = ($urandom_range(0, 3) != 0);
         data = int'($urandom_range(0, 'hFFFF));
         rv   = 1'b0;
         idx  = 0;
         if (pend.size() > 0 && $urandom_range(0, 3) != 0) begin
            rv  = 1'b1;
            idx = pend[$urandom_range(0, pend.size() - 1)];
         end else if ($urandom_range(0, 31) == 0) begin
            rv  = 1'b1;
            idx = int'($urandom_range(0, RobSize - 1));
         end
         alloc_valid_i = av;
         alloc_len_i   = LenW'(len);
         rsp_valid_i   = rv;
         rsp_idx_i     = IdxW'(idx);
         rsp_data_i    = DataWidth'(data);
         out_ready_i   = ordy;

         e_nf   = RobSize - m_used;
         e_tail = (m_head + m_used) % RobSize;
         e_ard  = (e_nf >= len + 1);
         e_ov   = m_valid[m_head];
         #1;
         check("rnd_out_valid", 32'(out_valid_o), 32'(e_ov));
         check("rnd_num_free", 32'(num_free_o), e_nf);
         check("rnd_alloc_ready", 32'(alloc_ready_o), 32'(e_ard));
         check("rnd_alloc_idx", 32'(alloc_idx_o), e_tail);
         check("rnd_err", 32'(err_o), m_err);
         if (e_ov) begin
            check("rnd_out_data", 32'(out_data_o), m_data[m_head]);
            check("rnd_out_last", 32'(out_last_o), 32'(m_last[m_head]));
         end
         @(posedge clk_i);

         wr_ok = m_alloc[idx] && !m_valid[idx];
         if (rv && wr_ok) begin
            m_valid[idx] = 1;
            m_data[idx]  = data;
         end else if (rv) begin
            m_err = 1;
         end
         if (e_ov && ordy) begin
            m_alloc[m_head] = 0;
            m_valid[m_head] = 0;
            m_head = (m_head + 1) % RobSize;
            m_used--;
         end
         if (av && e_ard) begin
            for (int k = 0; k <= len; k++) begin
               m_alloc[(e_tail + k) % RobSize] = 1;
               m_last[(e_tail + k) % RobSize]  = (k == len);
            end
            m_used += len + 1;
         end
         @(negedge clk_i);
      end
      idle();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
